iteration_result_collector: RTL
===============================

Name: iteration_result_collector

Overview:
- Consumer end of the iteration counter's done/clear interface. Sequences one frame of pixels: pulses `iter_clr` to start each pixel, waits for `iter_done`, and captures `iter_count`.
- Streams each result downstream over an AXI-Stream-style valid/ready master, with start-of-frame and end-of-line markers.
- Sits between the pipelined iteration datapath/counter and the frame writer.
- Also publishes the current pixel coordinate to the coordinate generator.

Parameters:
- COUNT_W, 24, width of the iteration count and stream data
- DIM_W, 12, width of frame dimensions and pixel coordinates

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-high (asserted = 1)
- start  in  1  single-cycle frame start request
- frame_width  in  DIM_W  pixels per line, sampled on accepted start
- frame_height  in  DIM_W  lines per frame, sampled on accepted start
- iter_count  in  COUNT_W  iteration count from the counter
- iter_done  in  1  counter's done/or_out flag (diverged or overflowed)
- iter_clr  out  1  one-cycle clear/restart pulse to the counter
- pixel_x  out  DIM_W  current pixel column
- pixel_y  out  DIM_W  current pixel row
- m_axis_tdata  out  COUNT_W  pixel result
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last pixel of a line
- m_axis_tuser  out  1  first pixel of a frame
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset (aresetn=1 at a clock edge):
  - state = IDLE.
  - All outputs 0, including tdata, pixel_x and pixel_y.
  - Stored width and height cleared.
  - Applies mid-frame: tvalid drops on that edge with no handshake; no further iter_clr is issued.
- FSM states: IDLE, CLR, RUN, SEND, DONE.
- IDLE:
  - Moves to CLR when start=1, frame_width!=0 and frame_height!=0; latches the dimensions and sets x=y=0.
  - A start with a zero dimension is ignored.
  - start in any other state is ignored.
- CLR:
  - iter_clr=1 for exactly this one cycle; next state RUN.
  - The counter resets on this same edge, so iter_done is 0 in the first RUN cycle.
- RUN:
  - Waits indefinitely for iter_done=1.
  - On that edge, register tdata <= iter_count (or the mapped colour), tvalid <= 1, tlast <= (x==width-1), tuser <= (x==0 && y==0); next state SEND.
- SEND:
  - tdata, tlast and tuser are held stable while tvalid=1 and tready=0.
  - On a handshake (tvalid & tready): tvalid <= 0.
    - If x==width-1 and y==height-1: next state DONE.
    - Else if x==width-1: x <= 0, y <= y+1; next state CLR.
    - Else x <= x+1; next state CLR.
  - iter_done changes while in SEND are ignored.
- DONE: frame_done=1 for one cycle; next state IDLE; x, y hold their final values.
- Latency:
  - Clear-to-capture is 1 (CLR) + N (RUN) cycles.
  - Zero-wait handshake to the next iter_clr is 1 cycle.
  - Minimum per-pixel period is 3 cycles plus the counter's run time.
- Width rules:
  - The captured count is COUNT_W bits, no arithmetic.
  - Coordinates compare at DIM_W; they never exceed width-1 / height-1.
  - A 1x1 frame yields a single beat with both tuser=1 and tlast=1.

Optional Feature:
- Macro: ITER_COLOUR_MAP_EN.
- Defined:
  - Adds input max_iterations [COUNT_W-1:0].
  - Captured data is in-set when iter_count + 4 > max_iterations, computed at COUNT_W+1 bits.
  - In-set tdata = 24'h000000; else tdata = {c[7:0], ~c[7:0], 8'h80}, where c = iter_count.
  - Mapping is combinational before the capture register; latency is unchanged.
- Undefined: tdata = raw iter_count and the max_iterations port is absent.

Decomposition:
- Package mandel_pkg holds:
  - the state enum (IDLE, CLR, RUN, SEND, DONE);
  - COUNT_W/DIM_W defaults;
  - the ITER_STEP=4 constant;
  - the in-set colour constant 24'h000000 and the fixed blue byte 8'h80.
- One sub-module, iter_colour_map (combinational; inputs iter_count and max_iterations; output colour). It is instantiated only under ITER_COLOUR_MAP_EN.

Test Plan:
- 2x2 frame, tready=1, iter_done 5 cycles after each clr with counts 4, 8, 12, 16:
  - four beats with tdata 4, 8, 12, 16;
  - tuser only on beat 0; tlast on beats 1 and 3;
  - exactly 4 iter_clr pulses, then one frame_done pulse, busy=0.
- Backpressure: hold tready=0 for 10 cycles in SEND:
  - tvalid, tdata, tlast and tuser are stable;
  - no iter_clr is issued;
  - an iter_done toggle in SEND is ignored;
  - on tready=1, exactly one beat transfers.
- start with frame_width=0 (height=3): stays IDLE, no iter_clr, busy=0. start while busy is ignored and the frame completes normally.
- Reset mid-frame, asserted during SEND of pixel (1,0) of a 3x1 frame:
  - next edge gives tvalid=0, busy=0, x=y=0, no frame_done.
  - A new start then restarts at (0,0) with tuser=1.
- 1x1 frame: a single beat with tuser=1 and tlast=1, followed by frame_done.
- ITER_COLOUR_MAP_EN with max_iterations=100:
  - count 100 gives tdata 000000;
  - count 40 (0x28) gives tdata 28D780.

Source files
------------

// File: rtl/mandel_pkg.sv
// ============================================================================
//  Package     : mandel_pkg
//  Description : Shared types and constants for the iteration result path
//                (collector FSM states, default widths, colour constants).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mandel_pkg;

  // Default widths of the iteration count and of frame coordinates
  localparam int COUNT_W_DEF = 24;
  localparam int DIM_W_DEF   = 12;

  // Headroom added to a count before comparing against the iteration limit
  localparam int ITER_STEP = 4;

  // Colour emitted for points judged to be inside the set
  localparam logic [23:0] IN_SET_COLOUR = 24'h000000;

  // Constant blue channel of the out-of-set colour ramp
  localparam logic [7:0] BLUE_BYTE = 8'h80;

  // Collector sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_colour_map.sv
// ============================================================================
//  Module      : iter_colour_map
//  Description : Combinational map from an iteration count to an RGB pixel.
//                Points whose count comes within ITER_STEP of the limit are
//                treated as in-set (black); others get a red/green ramp on
//                the low count byte with a fixed blue channel.
//                Only instantiated when ITER_COLOUR_MAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_colour_map
  import mandel_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic [COUNT_W-1:0] iter_count,
  input  logic [COUNT_W-1:0] max_iterations,
  output logic [COUNT_W-1:0] colour
);

  // One extra bit so count + step cannot wrap near the top of the range
  logic [COUNT_W:0] sum_w;
  logic             in_set_w;
  logic [23:0]      rgb_w;

  assign sum_w    = {1'b0, iter_count} + (COUNT_W+1)'(ITER_STEP);
  assign in_set_w = (sum_w > {1'b0, max_iterations});
  assign rgb_w    = {iter_count[7:0], ~iter_count[7:0], BLUE_BYTE};

  // Select black for in-set points, otherwise the ramp colour
  always_comb begin
    colour = in_set_w ? COUNT_W'(IN_SET_COLOUR) : COUNT_W'(rgb_w);
  end

endmodule

`default_nettype wire

// File: rtl/iteration_result_collector.sv
// ============================================================================
//  Module      : iteration_result_collector
//  Description : Walks one frame pixel by pixel: pulses iter_clr to restart
//                the iteration counter, waits for iter_done, captures the
//                count and streams it out on a valid/ready master with
//                tuser marking the first pixel of the frame and tlast the
//                last pixel of each line. Publishes the current coordinate.
//                Optional build macro ITER_COLOUR_MAP_EN replaces the raw
//                count with a mapped colour and adds the max_iterations port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iteration_result_collector
  import mandel_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int DIM_W   = DIM_W_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [DIM_W-1:0]   frame_width,
  input  logic [DIM_W-1:0]   frame_height,
  input  logic [COUNT_W-1:0] iter_count,
  input  logic               iter_done,
`ifdef ITER_COLOUR_MAP_EN
  input  logic [COUNT_W-1:0] max_iterations,
`endif
  output logic               iter_clr,
  output logic [DIM_W-1:0]   pixel_x,
  output logic [DIM_W-1:0]   pixel_y,
  output logic [COUNT_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic               busy,
  output logic               frame_done
);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d;
  logic [DIM_W-1:0]   y_q, y_d;
  logic [DIM_W-1:0]   width_q, width_d;
  logic [DIM_W-1:0]   height_q, height_d;
  logic [COUNT_W-1:0] tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               tuser_q, tuser_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Value that is captured into tdata when the counter reports done
  logic [COUNT_W-1:0] capture_w;
  logic               x_last_w;
  logic               y_last_w;

`ifdef ITER_COLOUR_MAP_EN
  iter_colour_map #(
    .COUNT_W (COUNT_W)
  ) u_colour_map (
    .iter_count     (iter_count),
    .max_iterations (max_iterations),
    .colour         (capture_w)
  );
`else
  assign capture_w = iter_count;
`endif

  // Stored dimensions are never zero while a frame runs, so width-1 is safe
  assign x_last_w = (x_q == (width_q  - DIM_W'(1)));
  assign y_last_w = (y_q == (height_q - DIM_W'(1)));

  // Next-state and next-output logic for the pixel sequencer
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;

    case (state_q)
      IDLE: begin
        // Zero-sized frames are dropped rather than started
        if (start && (frame_width != '0) && (frame_height != '0)) begin
          width_d  = frame_width;
          height_d = frame_height;
          x_d      = '0;
          y_d      = '0;
          state_d  = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
      end
      RUN: begin
        if (iter_done) begin
          tdata_d  = capture_w;
          tvalid_d = 1'b1;
          tlast_d  = x_last_w;
          tuser_d  = (x_q == '0) && (y_q == '0);
          state_d  = SEND;
        end
      end
      SEND: begin
        // Beat fields stay frozen until the consumer takes them
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          if (x_last_w && y_last_w) begin
            state_d = DONE;
          end else if (x_last_w) begin
            x_d     = '0;
            y_d     = y_q + DIM_W'(1);
            state_d = CLR;
          end else begin
            x_d     = x_q + DIM_W'(1);
            state_d = CLR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered images of the state being entered
    clr_d  = (state_d == CLR);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign iter_clr      = clr_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

`default_nettype wire
